// File: rtl/data_ram_arb_pkg.sv
// Shared types for the data RAM arbiter: grant states, master ids
// and the round-robin grant decision used on every clock edge.
package data_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Pick the next owner from live requests. On a tie the master
    // that was not granted last goes next, so neither can starve.
    function automatic state_e next_grant(
        input logic req0,
        input logic req1,
        input logic last_grant
    );
        state_e g;
        g = IDLE;
        if (req0 && req1) begin
            g = (last_grant == M0) ? ACC1 : ACC0;
        end else if (req0) begin
            g = ACC0;
        end else if (req1) begin
            g = ACC1;
        end
        return g;
    endfunction

endpackage

// File: rtl/data_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data RAM.
// Ports: m0_* (CPU) and m1_* (loader/debug) Avalon-style slaves with
// waitrequest; ram_* master port to the RAM (combinational read);
// protocol_error is a sticky flag for read+write issued together.
module data_ram_arbiter
    import data_ram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              protocol_error
);

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   protocol_error_q, protocol_error_d;

    logic req0, req1;
    logic rr_last;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            last_grant_q     <= M1;
            protocol_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        protocol_error_d = protocol_error_q;
        rr_last          = last_grant_q;

        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        ram_address    = '0;
        ram_read       = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;

        unique case (state_q)
            ACC0: begin
                m0_waitrequest = 1'b0;
                m0_readdata    = ram_readdata;
                ram_address    = m0_address;
                ram_writedata  = m0_writedata;
                // Write wins when both commands are raised together.
                ram_write      = m0_write;
                ram_read       = m0_read & ~m0_write;
                if (m0_read && m0_write) begin
                    protocol_error_d = 1'b1;
                end
                last_grant_d = M0;
                rr_last      = M0;
            end
            ACC1: begin
                m1_waitrequest = 1'b0;
                m1_readdata    = ram_readdata;
                ram_address    = m1_address;
                ram_writedata  = m1_writedata;
                ram_write      = m1_write;
                ram_read       = m1_read & ~m1_write;
                if (m1_read && m1_write) begin
                    protocol_error_d = 1'b1;
                end
                last_grant_d = M1;
                rr_last      = M1;
            end
            default: begin
            end
        endcase

        // Treating the current owner as "last" yields: other master
        // first, then back-to-back for the owner, else idle.
        state_d = next_grant(req0, req1, rr_last);
    end

    assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed scenarios plus a
// randomized two-master run against a transaction-level model.
module tb_data_ram_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] ram_address;
    logic        ram_read, ram_write;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;
    logic        protocol_error;

    logic [31:0] mem [0:63];
    logic        pre_en;
    logic [5:0]  pre_addr;
    logic [31:0] pre_data;

    int checks = 0;
    int errors = 0;

    data_ram_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .ram_address    (ram_address),
        .ram_read       (ram_read),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_readdata   (ram_readdata),
        .protocol_error (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: combinational read, write on the clock edge.
    assign ram_readdata = mem[ram_address[5:0]];
    always @(posedge clk) begin
        if (ram_write) mem[ram_address[5:0]] <= ram_writedata;
        else if (pre_en) mem[pre_addr] <= pre_data;
    end

    task automatic clear_inputs();
        m0_read = 0; m0_write = 0; m0_address = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_writedata = 0;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pre_en = 1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        clear_inputs();
        reset = 1; #2; reset = 0;
    endtask

    task automatic test_reset();
        #2;
        m0_read = 1; m1_write = 1; m0_address = 32'h10; m1_address = 32'h11;
        #1;
        checks++;
        if (m0_waitrequest !== 1 || m1_waitrequest !== 1 || ram_read !== 0 ||
            ram_write !== 0 || ram_address !== 0 || ram_writedata !== 0 ||
            m0_readdata !== 0 || m1_readdata !== 0 || protocol_error !== 0) begin
            errors++;
            $display("FAIL reset_outputs: w0=%b w1=%b rd=%b wr=%b addr=%h perr=%b want w=1 rd/wr/addr/perr=0",
                     m0_waitrequest, m1_waitrequest, ram_read, ram_write, ram_address, protocol_error);
        end
        clear_inputs();
        @(posedge clk); #1;
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (m0_waitrequest !== 1 || m1_waitrequest !== 1 ||
                ram_write !== 0 || protocol_error !== 0) begin
                errors++;
                $display("FAIL idle_after_reset cyc %0d: w0=%b w1=%b wr=%b perr=%b want 1 1 0 0",
                         c, m0_waitrequest, m1_waitrequest, ram_write, protocol_error);
            end
        end
    endtask

    task automatic test_m0_write();
        @(posedge clk); #1;
        m0_write = 1; m0_address = 32'd4; m0_writedata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1) begin
            errors++;
            $display("FAIL m0_write_wait1: got %b want 1", m0_waitrequest);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 0 || ram_write !== 1 || ram_address !== 32'd4 ||
            ram_writedata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL m0_write_cyc2: w=%b wr=%b addr=%h data=%h want 0 1 4 deadbeef",
                     m0_waitrequest, ram_write, ram_address, ram_writedata);
        end
        @(posedge clk); #1;
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL m0_write_mem: got %h want deadbeef", mem[4]);
        end
        m0_write = 0; m0_read = 1;
        begin : rd_wait
            int n;
            n = 0;
            @(negedge clk);
            while (m0_waitrequest && n < 5) begin
                @(posedge clk); #1;
                @(negedge clk);
                n++;
            end
            checks++;
            if (m0_waitrequest !== 0 || m0_readdata !== 32'hDEADBEEF || ram_write !== 0) begin
                errors++;
                $display("FAIL m0_read: w=%b data=%h wr=%b want 0 deadbeef 0",
                         m0_waitrequest, m0_readdata, ram_write);
            end
        end
        go_idle();
    endtask

    task automatic test_contention();
        preload(6'd5, 32'h12345678);
        pulse_reset();
        m0_read = 1; m0_address = 32'd4;
        m1_read = 1; m1_address = 32'd5;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1 || m1_waitrequest !== 1) begin
            errors++;
            $display("FAIL contend_idle: w0=%b w1=%b want 1 1", m0_waitrequest, m1_waitrequest);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (m0_waitrequest !== logic'(k % 2 != 0) ||
                m1_waitrequest !== logic'(k % 2 == 0)) begin
                errors++;
                $display("FAIL contend_alt %0d: w0=%b w1=%b want owner m%0d",
                         k, m0_waitrequest, m1_waitrequest, k % 2);
            end
            checks++;
            if (k % 2 == 0 && (m0_readdata !== 32'hDEADBEEF || m1_readdata !== 0)) begin
                errors++;
                $display("FAIL contend_data0 %0d: r0=%h r1=%h want deadbeef 0",
                         k, m0_readdata, m1_readdata);
            end else if (k % 2 == 1 && (m1_readdata !== 32'h12345678 || m0_readdata !== 0)) begin
                errors++;
                $display("FAIL contend_data1 %0d: r1=%h r0=%h want 12345678 0",
                         k, m1_readdata, m0_readdata);
            end
        end
        go_idle();
    endtask

    task automatic test_stream(input logic [31:0] base, input bit inject);
        int i, cyc, m0_waits;
        bit issued;
        i = 0; cyc = 0; m0_waits = 0; issued = 0;
        @(posedge clk); #1;
        m1_write = 1; m1_address = 0; m1_writedata = base;
        while (i < 8 && cyc < 40) begin
            bit s0, s1;
            @(negedge clk);
            cyc++;
            s1 = !m1_waitrequest;
            s0 = !m0_waitrequest && m0_read;
            if (m0_read && m0_waitrequest) m0_waits++;
            if (s0) begin
                checks++;
                if (m0_readdata !== base + 32'd2) begin
                    errors++;
                    $display("FAIL stream_inject_data: got %h want %h", m0_readdata, base + 32'd2);
                end
            end
            @(posedge clk); #1;
            if (s1) begin
                i++;
                if (i < 8) begin
                    m1_address = i;
                    m1_writedata = base + i;
                end else begin
                    m1_write = 0;
                end
            end
            if (s0) m0_read = 0;
            if (inject && i == 4 && !issued) begin
                issued = 1;
                m0_read = 1; m0_address = 32'd2;
            end
        end
        checks++;
        if (cyc !== (inject ? 10 : 9)) begin
            errors++;
            $display("FAIL stream_cycles: got %0d want %0d", cyc, inject ? 10 : 9);
        end
        if (inject) begin
            checks++;
            if (m0_waits !== 1 || m0_read !== 0) begin
                errors++;
                $display("FAIL stream_inject_wait: waits %0d pending %b want 1 0", m0_waits, m0_read);
            end
        end
        for (int a = 0; a < 8; a++) begin
            checks++;
            if (mem[a] !== base + a) begin
                errors++;
                $display("FAIL stream_mem[%0d]: got %h want %h", a, mem[a], base + a);
            end
        end
        go_idle();
    endtask

    task automatic test_protocol_error();
        int n;
        checks++;
        if (protocol_error !== 0) begin
            errors++;
            $display("FAIL perr_before: got %b want 0", protocol_error);
        end
        m0_read = 1; m0_write = 1; m0_address = 32'd8; m0_writedata = 32'h55;
        n = 0;
        @(negedge clk);
        while (m0_waitrequest && n < 5) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (m0_waitrequest !== 0 || ram_write !== 1 || ram_read !== 0) begin
            errors++;
            $display("FAIL perr_cmd: w=%b wr=%b rd=%b want 0 1 0", m0_waitrequest, ram_write, ram_read);
        end
        @(posedge clk); #1;
        clear_inputs();
        checks++;
        if (protocol_error !== 1 || mem[8] !== 32'h55) begin
            errors++;
            $display("FAIL perr_set: perr=%b mem8=%h want 1 55", protocol_error, mem[8]);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (protocol_error !== 1) begin
            errors++;
            $display("FAIL perr_sticky: got %b want 1", protocol_error);
        end
    endtask

    task automatic test_mid_reset();
        preload(6'd9, 32'h1111);
        @(posedge clk); #1;
        m1_write = 1; m1_address = 32'd9; m1_writedata = 32'hAAAA;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (m1_waitrequest !== 0 || ram_write !== 1) begin
            errors++;
            $display("FAIL midrst_acc1: w1=%b wr=%b want 0 1", m1_waitrequest, ram_write);
        end
        #2;
        reset = 1;
        #1;
        checks++;
        if (m0_waitrequest !== 1 || m1_waitrequest !== 1 || ram_write !== 0 ||
            ram_address !== 0 || m1_readdata !== 0) begin
            errors++;
            $display("FAIL midrst_async: w0=%b w1=%b wr=%b addr=%h want 1 1 0 0",
                     m0_waitrequest, m1_waitrequest, ram_write, ram_address);
        end
        @(posedge clk); #1;
        checks++;
        if (mem[9] !== 32'h1111) begin
            errors++;
            $display("FAIL midrst_mem: got %h want 1111", mem[9]);
        end
        clear_inputs();
        reset = 0;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1 || m1_waitrequest !== 1 || ram_read !== 0 ||
            ram_write !== 0 || protocol_error !== 0) begin
            errors++;
            $display("FAIL midrst_idle: w0=%b w1=%b rd=%b wr=%b perr=%b want 1 1 0 0 0",
                     m0_waitrequest, m1_waitrequest, ram_read, ram_write, protocol_error);
        end
    endtask

    task automatic new_req(input int m);
        bit go, wr;
        logic [31:0] a, d;
        go = ($urandom_range(0, 9) < 7);
        wr = $urandom_range(0, 1) == 1;
        a = 32'd16 + $urandom_range(0, 15);
        d = $urandom;
        if (m == 0) begin
            m0_read = go && !wr; m0_write = go && wr; m0_address = a; m0_writedata = d;
        end else begin
            m1_read = go && !wr; m1_write = go && wr; m1_address = a; m1_writedata = d;
        end
    endtask

    // Model: an owner (-1 idle) plus a shadow memory; each granted
    // transaction is applied to the shadow and reads are compared.
    task automatic test_random();
        logic [31:0] mm [0:63];
        int owner, last, nxt, base;
        bit r0, r1, s0, s1;
        pulse_reset();
        for (int a = 0; a < 64; a++) mm[a] = mem[a];
        owner = -1; last = 1;
        new_req(0); new_req(1);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (m0_waitrequest !== logic'(owner != 0) || m1_waitrequest !== logic'(owner != 1)) begin
                errors++;
                $display("FAIL rand_wait cyc %0d: w0=%b w1=%b want owner %0d",
                         c, m0_waitrequest, m1_waitrequest, owner);
            end
            if (owner == 0) begin
                checks++;
                if (m1_readdata !== 0 || (m0_read && m0_readdata !== mm[m0_address[5:0]])) begin
                    errors++;
                    $display("FAIL rand_rd0 cyc %0d: r0=%h r1=%h want %h 0",
                             c, m0_readdata, m1_readdata, mm[m0_address[5:0]]);
                end
                if (m0_write) mm[m0_address[5:0]] = m0_writedata;
            end else if (owner == 1) begin
                checks++;
                if (m0_readdata !== 0 || (m1_read && m1_readdata !== mm[m1_address[5:0]])) begin
                    errors++;
                    $display("FAIL rand_rd1 cyc %0d: r1=%h r0=%h want %h 0",
                             c, m1_readdata, m0_readdata, mm[m1_address[5:0]]);
                end
                if (m1_write) mm[m1_address[5:0]] = m1_writedata;
            end
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            base = (owner >= 0) ? owner : last;
            if (owner >= 0) last = owner;
            if (r0 && r1) nxt = 1 - base;
            else if (r0) nxt = 0;
            else if (r1) nxt = 1;
            else nxt = -1;
            s0 = (owner == 0) || !r0;
            s1 = (owner == 1) || !r1;
            @(posedge clk); #1;
            if (c > 390) begin
                clear_inputs();
            end else begin
                if (s0) new_req(0);
                if (s1) new_req(1);
            end
            owner = nxt;
        end
        go_idle();
        for (int a = 16; a < 32; a++) begin
            checks++;
            if (mem[a] !== mm[a]) begin
                errors++;
                $display("FAIL rand_mem[%0d]: got %h want %h", a, mem[a], mm[a]);
            end
        end
    endtask

    initial begin
        reset = 1;
        pre_en = 0; pre_addr = 0; pre_data = 0;
        clear_inputs();
        test_reset();
        test_m0_write();
        test_contention();
        test_stream(32'h100, 0);
        test_stream(32'h200, 1);
        test_protocol_error();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
